// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with exact count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered dout.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic wr_allow, rd_allow;
  assign full         = count == (ADDR_WIDTH+1)'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= (ADDR_WIDTH+1)'(AF_LEVEL);
  assign almost_empty = count <= (ADDR_WIDTH+1)'(AE_LEVEL);
  assign wr_allow     = wr_en & !full;
  assign rd_allow     = rd_en & !empty;
  always_ff @(posedge clk)
    if (wr_allow) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_allow ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
      rd_ptr    <= rd_allow ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
      count     <= count + (ADDR_WIDTH+1)'(wr_allow) - (ADDR_WIDTH+1)'(rd_allow);
      // a fresh error in the same cycle wins over clr_err
      overflow  <= (wr_en & full) | (overflow & !clr_err);
      underflow <= (rd_en & empty) | (underflow & !clr_err);
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign dout = mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) dout <= '0;
    else if (rd_allow) dout <= mem[rd_ptr];
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: vector table, corner sequences and random traffic against a queue model.
module tb_sync_fifo_flags;
  localparam int DEPTH = 16, AF = 12, AE = 2;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [31:0] din = '0, dout;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int checks = 0, errors = 0;
  logic [31:0] q [$];
  logic m_ovf = 1'b0, m_unf = 1'b0;
  logic [31:0] m_dout = '0;
  typedef struct {
    logic w; logic [31:0] d; logic r; logic c;
    int cnt; logic ovf; logic unf; logic dchk; logic [31:0] dv;
  } vec_t;
  vec_t tv [35];

  sync_fifo_flags #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic chk_count_flags(input string t, input int n, input logic ov, input logic un);
    chk({t, " count"}, 64'(count), 64'(n));
    chk({t, " empty"}, 64'(empty), 64'(n == 0));
    chk({t, " full"}, 64'(full), 64'(n == DEPTH));
    chk({t, " almost_full"}, 64'(almost_full), 64'(n >= AF));
    chk({t, " almost_empty"}, 64'(almost_empty), 64'(n <= AE));
    chk({t, " overflow"}, 64'(overflow), 64'(ov));
    chk({t, " underflow"}, 64'(underflow), 64'(un));
  endtask

  task automatic chk_model(input string t);
    chk_count_flags(t, q.size(), m_ovf, m_unf);
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() > 0) chk({t, " dout"}, 64'(dout), 64'(q[0]));
`else
    chk({t, " dout"}, 64'(dout), 64'(m_dout));
`endif
  endtask

  task automatic chk_reset(input string t);
    chk_count_flags(t, 0, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chk({t, " dout"}, 64'(dout), 64'h0);
`endif
  endtask

  task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic c);
    bit f, e;
    f = q.size() == DEPTH;
    e = q.size() == 0;
    wr_en = w; din = d; rd_en = r; clr_err = c;
    @(posedge clk);
    #1;
    m_ovf = (w & f) | (m_ovf & !c);
    m_unf = (r & e) | (m_unf & !c);
    if (r && !e) m_dout = q.pop_front();
    if (w && !f) q.push_back(d);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    chk_model("model");
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      tv[i] = '{1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, i + 1, 1'b0, 1'b0, 1'b1, 32'h0};
    tv[16] = '{1'b1, 32'hDEAD, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 16; i++)
      tv[17+i] = '{1'b0, 32'h0, 1'b1, 1'b0, 15 - i, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(i)};
    tv[33] = '{1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 32'h10F};
    tv[34] = '{1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 35; i++) begin
      cyc(tv[i].w, tv[i].d, tv[i].r, tv[i].c);
      chk_count_flags($sformatf("vec%0d", i), tv[i].cnt, tv[i].ovf, tv[i].unf);
`ifndef SYNC_FIFO_FWFT_EN
      if (tv[i].dchk) chk($sformatf("vec%0d dout", i), 64'(dout), 64'(tv[i].dv));
`endif
    end

    // sustained simultaneous traffic at count 5 across pointer wrap
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'h200 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 32'h300 + 32'(k), 1'b1, 1'b0);
      chk("wrap count", 64'(count), 64'd5);
`ifdef SYNC_FIFO_FWFT_EN
      chk("wrap head", 64'(dout), 64'((k + 1 < 5) ? 32'h200 + 32'(k + 1) : 32'h300 + 32'(k - 4)));
`else
      chk("wrap dout", 64'(dout), 64'((k < 5) ? 32'h200 + 32'(k) : 32'h300 + 32'(k - 5)));
`endif
    end

    while (q.size() < DEPTH) cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 1'b1, 1'b0);
    chk("full both count", 64'(count), 64'd15);
    chk("full both overflow", 64'(overflow), 64'd1);
    while (q.size() > 0) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    chk("empty both count", 64'(count), 64'd1);
    chk("empty both underflow", 64'(underflow), 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr overflow", 64'(overflow), 64'd0);
    chk("clr underflow", 64'(underflow), 64'd0);

    while (q.size() < 9) cyc(1'b1, $urandom, 1'b0, 1'b0);
    chk("pre-reset count", 64'(count), 64'd9);
    #2 rst = 1'b1;
    #1 chk_reset("async reset");
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    @(posedge clk);
    #1 chk_reset("held reset");
    #3 rst = 1'b0;
    cyc(1'b1, 32'hABCD, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post-reset head", 64'(dout), 64'h ABCD);
`endif
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("post-reset dout", 64'(dout), 64'hABCD);
`endif

    for (int k = 0; k < 3000; k++) begin
      int wp;
      wp = ((k / 300) % 2 == 0) ? 70 : 30;
      cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < 100 - wp,
          $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
